// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised raster timing generator. Advances one pixel per
//            clock on which PIX_CE is high and produces sync, display enable,
//            pixel coordinates, line/frame strobes and a frame counter.
// Ports    : CLK         - system clock, rising edge
//            RST         - synchronous reset, active-high
//            PIX_CE      - pixel advance enable
//            H_SYNC      - horizontal sync, active level H_POL
//            V_SYNC      - vertical sync, active level V_POL
//            DE          - display enable (active area)
//            PIX_X       - current horizontal position
//            PIX_Y       - current vertical position
//            LINE_START  - one-cycle strobe when PIX_X is loaded with 0
//            FRAME_START - one-cycle strobe when (0,0) is loaded
//            FRAME_CNT   - completed frames, modulo 256
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SW     = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SW     = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int HW       = 11,
    parameter int VW       = 11
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          PIX_CE,
    output logic          H_SYNC,
    output logic          V_SYNC,
    output logic          DE,
    output logic [HW-1:0] PIX_X,
    output logic [VW-1:0] PIX_Y,
    output logic          LINE_START,
    output logic          FRAME_START,
    output logic [7:0]    FRAME_CNT
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SW + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SW + V_BP;

    localparam logic [HW-1:0] c_H_LAST = HW'(c_H_TOTAL - 1);
    localparam logic [VW-1:0] c_V_LAST = VW'(c_V_TOTAL - 1);

    // Region boundaries kept 32 bits wide so an end bound equal to the total
    // never overflows the counter width.
    localparam logic [31:0] c_H_ACT_END = 32'(H_ACTIVE);
    localparam logic [31:0] c_HS_START  = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] c_HS_END    = 32'(H_ACTIVE + H_FP + H_SW);
    localparam logic [31:0] c_V_ACT_END = 32'(V_ACTIVE);
    localparam logic [31:0] c_VS_START  = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] c_VS_END    = 32'(V_ACTIVE + V_FP + V_SW);

    logic [HW-1:0] r_x;
    logic [VW-1:0] r_y;
    logic [7:0]    r_frame_cnt;
    logic          r_h_sync;
    logic          r_v_sync;
    logic          r_de;
    logic          r_line_start;
    logic          r_frame_start;
    // Set while the counters still hold the reset preload: the wrap out of
    // the preload position starts the first frame but completes none.
    logic          r_preload;

    logic          w_x_wrap;
    logic          w_y_wrap;
    logic [HW-1:0] w_x_nxt;
    logic [VW-1:0] w_y_nxt;
    logic [31:0]   w_x_nxt32;
    logic [31:0]   w_y_nxt32;
    logic          w_h_sync_rgn;
    logic          w_v_sync_rgn;
    logic          w_de_nxt;

    always_comb begin
        w_x_wrap  = (r_x == c_H_LAST);
        w_y_wrap  = (r_y == c_V_LAST);
        w_x_nxt   = w_x_wrap ? '0 : r_x + HW'(1);
        w_y_nxt   = r_y;
        if (w_x_wrap) begin
            w_y_nxt = w_y_wrap ? '0 : r_y + VW'(1);
        end
        // Decode from the next position so sync/DE line up with PIX_X/PIX_Y.
        w_x_nxt32    = 32'(w_x_nxt);
        w_y_nxt32    = 32'(w_y_nxt);
        w_h_sync_rgn = (w_x_nxt32 >= c_HS_START) && (w_x_nxt32 < c_HS_END);
        w_v_sync_rgn = (w_y_nxt32 >= c_VS_START) && (w_y_nxt32 < c_VS_END);
        w_de_nxt     = (w_x_nxt32 < c_H_ACT_END) && (w_y_nxt32 < c_V_ACT_END);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_x           <= c_H_LAST;
            r_y           <= c_V_LAST;
            r_frame_cnt   <= 8'd0;
            r_h_sync      <= ~H_POL;
            r_v_sync      <= ~V_POL;
            r_de          <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_preload     <= 1'b1;
        end else if (PIX_CE) begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_h_sync      <= w_h_sync_rgn ? H_POL : ~H_POL;
            r_v_sync      <= w_v_sync_rgn ? V_POL : ~V_POL;
            r_de          <= w_de_nxt;
            r_line_start  <= w_x_wrap;
            r_frame_start <= w_x_wrap && w_y_wrap;
            r_preload     <= 1'b0;
            if (w_x_wrap && w_y_wrap && !r_preload) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end else begin
            // Position holds; strobes mark advances only.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign PIX_X       = r_x;
    assign PIX_Y       = r_y;
    assign FRAME_CNT   = r_frame_cnt;
    assign H_SYNC      = r_h_sync;
    assign V_SYNC      = r_v_sync;
    assign DE          = r_de;
    assign LINE_START  = r_line_start;
    assign FRAME_START = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Self-checking bench for vga_timing_gen. Two instances run side
//            by side: default 800x525 mode and a tiny 8x6 mode with positive
//            sync polarity. A count-of-advances model predicts every output.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- default-mode instance ----------------
    logic        rst_d = 1'b1;
    logic        ce_d  = 1'b0;
    logic        d_hs, d_vs, d_de, d_ls, d_fs;
    logic [10:0] d_x;
    logic [10:0] d_y;
    logic [7:0]  d_fc;

    vga_timing_gen u_dut_def (
        .CLK(clk), .RST(rst_d), .PIX_CE(ce_d),
        .H_SYNC(d_hs), .V_SYNC(d_vs), .DE(d_de),
        .PIX_X(d_x), .PIX_Y(d_y),
        .LINE_START(d_ls), .FRAME_START(d_fs), .FRAME_CNT(d_fc)
    );

    // ---------------- small-mode instance ----------------
    logic       rst_s = 1'b1;
    logic       ce_s  = 1'b0;
    logic       s_hs, s_vs, s_de, s_ls, s_fs;
    logic [3:0] s_x;
    logic [3:0] s_y;
    logic [7:0] s_fc;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SW(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SW(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .HW(4), .VW(4)
    ) u_dut_small (
        .CLK(clk), .RST(rst_s), .PIX_CE(ce_s),
        .H_SYNC(s_hs), .V_SYNC(s_vs), .DE(s_de),
        .PIX_X(s_x), .PIX_Y(s_y),
        .LINE_START(s_ls), .FRAME_START(s_fs), .FRAME_CNT(s_fc)
    );

    // ---------------- model ----------------
    // The raster is fully determined by n, the number of pixel advances since
    // reset: n=0 is the preload, otherwise pixel index p=n-1 in raster order.
    typedef struct {
        longint x;
        longint y;
        longint fc;
        bit     hs;
        bit     vs;
        bit     de;
        bit     ls;
        bit     fs;
    } exp_t;

    function automatic exp_t model(input longint n, input bit adv,
                                   input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb,
                                   input bit hp, input bit vp);
        exp_t   e;
        longint ht = ha + hf + hsw + hb;
        longint vt = va + vf + vsw + vb;
        longint p;
        if (n == 0) begin
            e.x = ht - 1; e.y = vt - 1; e.fc = 0;
            e.hs = !hp; e.vs = !vp; e.de = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
        end else begin
            p    = n - 1;
            e.x  = p % ht;
            e.y  = (p / ht) % vt;
            e.fc = (p / (ht * vt)) % 256;
            e.hs = (e.x >= ha + hf && e.x < ha + hf + hsw) ? hp : !hp;
            e.vs = (e.y >= va + vf && e.y < va + vf + vsw) ? vp : !vp;
            e.de = (e.x < ha) && (e.y < va);
            e.ls = adv && (e.x == 0);
            e.fs = adv && (e.x == 0) && (e.y == 0);
        end
        return e;
    endfunction

    longint n_d = 0;
    longint n_s = 0;
    bit     adv_d = 1'b0;
    bit     adv_s = 1'b0;
    bit     chk_en_d = 1'b0;
    bit     chk_en_s = 1'b0;

    always @(posedge clk) begin
        if (rst_d) begin
            n_d <= 0; adv_d <= 1'b0;
        end else begin
            if (ce_d) n_d <= n_d + 1;
            adv_d <= ce_d;
        end
        if (rst_s) begin
            n_s <= 0; adv_s <= 1'b0;
        end else begin
            if (ce_s) n_s <= n_s + 1;
            adv_s <= ce_s;
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (chk_en_d) begin
            e = model(n_d, adv_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
            chk("d_x",  longint'(d_x),  e.x);
            chk("d_y",  longint'(d_y),  e.y);
            chk("d_fc", longint'(d_fc), e.fc);
            chk("d_hs", longint'(d_hs), longint'(e.hs));
            chk("d_vs", longint'(d_vs), longint'(e.vs));
            chk("d_de", longint'(d_de), longint'(e.de));
            chk("d_ls", longint'(d_ls), longint'(e.ls));
            chk("d_fs", longint'(d_fs), longint'(e.fs));
        end
        if (chk_en_s) begin
            e = model(n_s, adv_s, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
            chk("s_x",  longint'(s_x),  e.x);
            chk("s_y",  longint'(s_y),  e.y);
            chk("s_fc", longint'(s_fc), e.fc);
            chk("s_hs", longint'(s_hs), longint'(e.hs));
            chk("s_vs", longint'(s_vs), longint'(e.vs));
            chk("s_de", longint'(s_de), longint'(e.de));
            chk("s_ls", longint'(s_ls), longint'(e.ls));
            chk("s_fs", longint'(s_fs), longint'(e.fs));
        end
    end

    bit done_d = 1'b0;
    bit done_s = 1'b0;

    // ---------------- default-mode directed stimulus ----------------
    initial begin : stim_def
        int ls_cnt;
        int fs_cnt;
        rst_d = 1'b1; ce_d = 1'b0;
        @(negedge clk); @(negedge clk);
        chk_en_d = 1'b1;
        chk("d_rst_x",  longint'(d_x),  799);
        chk("d_rst_y",  longint'(d_y),  524);
        chk("d_rst_hs", longint'(d_hs), 1);
        chk("d_rst_vs", longint'(d_vs), 1);
        chk("d_rst_de", longint'(d_de), 0);
        chk("d_rst_fc", longint'(d_fc), 0);

        rst_d = 1'b0; ce_d = 1'b1;
        for (int k = 1; k <= 1700; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("d_first_x",  longint'(d_x),  0);
                chk("d_first_y",  longint'(d_y),  0);
                chk("d_first_de", longint'(d_de), 1);
                chk("d_first_ls", longint'(d_ls), 1);
                chk("d_first_fs", longint'(d_fs), 1);
                chk("d_first_fc", longint'(d_fc), 0);
            end
            if (k == 656) chk("d_hs_x655", longint'(d_hs), 1);
            if (k == 657) chk("d_hs_x656", longint'(d_hs), 0);
            if (k == 752) chk("d_hs_x751", longint'(d_hs), 0);
            if (k == 753) chk("d_hs_x752", longint'(d_hs), 1);
            if (k == 641) chk("d_de_x640", longint'(d_de), 0);
            if (k == 800) chk("d_ls_x799", longint'(d_ls), 0);
            if (k == 801) begin
                chk("d_line2_ls", longint'(d_ls), 1);
                chk("d_line2_x",  longint'(d_x),  0);
                chk("d_line2_y",  longint'(d_y),  1);
                chk("d_line2_fs", longint'(d_fs), 0);
            end
        end

        // Pixel enable every 4th clock for 800 advances: exactly one line
        // start is crossed and each strobe lasts a single clock.
        ls_cnt = 0;
        fs_cnt = 0;
        for (int i = 0; i < 3200; i++) begin
            ce_d = (i % 4 == 0);
            @(negedge clk);
            if (d_ls) ls_cnt++;
            if (d_fs) fs_cnt++;
        end
        chk("d_pulse_ls_cycles", ls_cnt, 1);
        chk("d_pulse_fs_cycles", fs_cnt, 0);

        // Reset together with pixel enable mid-frame.
        ce_d = 1'b1; rst_d = 1'b1;
        @(negedge clk);
        chk("d_midrst_x",  longint'(d_x),  799);
        chk("d_midrst_y",  longint'(d_y),  524);
        chk("d_midrst_de", longint'(d_de), 0);
        chk("d_midrst_ls", longint'(d_ls), 0);
        rst_d = 1'b0;
        @(negedge clk);
        chk("d_restart_x",  longint'(d_x),  0);
        chk("d_restart_y",  longint'(d_y),  0);
        chk("d_restart_fs", longint'(d_fs), 1);
        chk("d_restart_fc", longint'(d_fc), 0);
        ce_d = 1'b0;
        @(negedge clk);
        chk("d_hold_fs", longint'(d_fs), 0);
        chk("d_hold_x",  longint'(d_x),  0);
        repeat (3) @(negedge clk);
        done_d = 1'b1;
    end

    // ---------------- small-mode directed stimulus ----------------
    initial begin : stim_small
        int ls_cnt;
        int de_cnt;
        int vs_cnt;
        int fs_cnt;
        rst_s = 1'b1; ce_s = 1'b0;
        @(negedge clk); @(negedge clk);
        chk_en_s = 1'b1;
        chk("s_rst_x",  longint'(s_x),  7);
        chk("s_rst_y",  longint'(s_y),  5);
        chk("s_rst_hs", longint'(s_hs), 0);
        chk("s_rst_vs", longint'(s_vs), 0);

        ls_cnt = 0; de_cnt = 0; vs_cnt = 0; fs_cnt = 0;
        rst_s = 1'b0; ce_s = 1'b1;
        for (int k = 1; k <= 48 * 256 + 8; k++) begin
            @(negedge clk);
            if (k <= 48) begin
                if (s_ls) ls_cnt++;
                if (s_de) de_cnt++;
                if (s_vs) vs_cnt++;
                if (s_fs) fs_cnt++;
            end
            if (k == 48) begin
                chk("s_frame_lines",  ls_cnt, 6);
                chk("s_frame_de",     de_cnt, 12);
                chk("s_frame_vs_clk", vs_cnt, 8);
                chk("s_frame_fs",     fs_cnt, 1);
            end
            if (k == 5) chk("s_hs_x4", longint'(s_hs), 0);
            if (k == 6) chk("s_hs_x5", longint'(s_hs), 1);
            if (k == 7) chk("s_hs_x6", longint'(s_hs), 1);
            if (k == 8) chk("s_hs_x7", longint'(s_hs), 0);
            if (k == 9) chk("s_ls_line1", longint'(s_ls), 1);
            if (k == 33) chk("s_vs_y4", longint'(s_vs), 1);
            if (k == 41) chk("s_vs_y5", longint'(s_vs), 0);
            if (k == 49) begin
                chk("s_fs_frame2", longint'(s_fs), 1);
                chk("s_fc_frame2", longint'(s_fc), 1);
            end
            if (k == 48 * 256)     chk("s_fc_255", longint'(s_fc), 255);
            if (k == 48 * 256 + 1) begin
                chk("s_fc_wrap",    longint'(s_fc), 0);
                chk("s_fs_wrap",    longint'(s_fs), 1);
            end
        end
        done_s = 1'b1;
    end

    // ---------------- completion ----------------
    initial begin : finisher
        int budget;
        budget = 0;
        while (!(done_d && done_s) && budget < 40000) begin
            @(posedge clk);
            budget++;
        end
        checks++;
        if (!(done_d && done_s)) begin
            errors++;
            $display("FAIL timeout: done_d=%0d done_s=%0d after %0d cycles", done_d, done_s, budget);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
